ysyx_25040129_wbu: RTL and testbench

Write-back / commit stage directly downstream of the load-store unit.
- Accepts one retired instruction per valid/ready handshake.
- Commits the GPR write and CSR/trap side effects in exactly one cycle.
- Computes the next PC and hands it to the IFU over a valid/ready handshake.
- Owns the machine CSRs mstatus, mtvec, mepc and mcause, and provides a combinational CSR read port to the upstream stages.

---
 rtl/ysyx_25040129_wbu_pkg.sv | 24 ++
 rtl/ysyx_25040129_csr_file.sv | 61 ++++++
 rtl/ysyx_25040129_wbu.sv | 106 ++++++++++
 tb/tb_ysyx_25040129_wbu.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040129_wbu_pkg.sv
// ysyx_25040129_wbu_pkg: shared FSM encoding, CSR map and bus constants for the write-back stage
package ysyx_25040129_wbu_pkg;
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COMMIT   = 2'd1,
      WAIT_IFU = 2'd2
   } wbu_state_e;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [31:0] ECALL_CAUSE_VAL = 32'd11;
   localparam logic [31:0] MSTATUS_RST_VAL = 32'h0000_1800;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   localparam logic [2:0] MEM_OP_B  = 3'b000;
   localparam logic [2:0] MEM_OP_H  = 3'b001;
   localparam logic [2:0] MEM_OP_W  = 3'b010;
   localparam logic [2:0] MEM_OP_BU = 3'b100;
   localparam logic [2:0] MEM_OP_HU = 3'b101;
endpackage

// File: rtl/ysyx_25040129_csr_file.sv
// ysyx_25040129_csr_file: machine CSRs with write port, ecall trap update and combinational read port
module ysyx_25040129_csr_file
   import ysyx_25040129_wbu_pkg::*;
#(
   parameter logic [31:0] MSTATUS_RST = MSTATUS_RST_VAL,
   parameter logic [31:0] ECALL_CAUSE = ECALL_CAUSE_VAL
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        commit_i,
   input  logic        ecall_i,
   input  logic        mret_i,
   input  logic        wen_i,
   input  logic [11:0] waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] pc_i,
   input  logic [11:0] raddr_i,
   output logic [31:0] rdata_o,
   output logic [31:0] mtvec_o,
   output logic [31:0] mepc_o
);
   logic [31:0] mstatus_q, mtvec_q, mepc_q, mcause_q;
   logic [31:0] mstatus_d, mtvec_d, mepc_d, mcause_d;
   logic        wr;

   // next-state: ecall trap beats mret, mret beats a plain CSR write
   always_comb begin
      wr        = commit_i && !ecall_i && !mret_i && wen_i;
      mstatus_d = wr && waddr_i == CSR_MSTATUS ? wdata_i : mstatus_q;
      mtvec_d   = wr && waddr_i == CSR_MTVEC ? wdata_i : mtvec_q;
      mepc_d    = commit_i && ecall_i ? {pc_i[31:2], 2'b00} :
                  wr && waddr_i == CSR_MEPC ? {wdata_i[31:2], 2'b00} : mepc_q;
      mcause_d  = commit_i && ecall_i ? ECALL_CAUSE :
                  wr && waddr_i == CSR_MCAUSE ? wdata_i : mcause_q;
   end

   // CSR storage; reset overrides any commit in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus_q <= MSTATUS_RST;
         mtvec_q   <= '0;
         mepc_q    <= '0;
         mcause_q  <= '0;
      end else begin
         mstatus_q <= mstatus_d;
         mtvec_q   <= mtvec_d;
         mepc_q    <= mepc_d;
         mcause_q  <= mcause_d;
      end
   end

   // read port sees stored contents only; unmapped addresses read zero
   always_comb begin
      rdata_o = raddr_i == CSR_MSTATUS ? mstatus_q :
                raddr_i == CSR_MTVEC   ? mtvec_q   :
                raddr_i == CSR_MEPC    ? mepc_q    :
                raddr_i == CSR_MCAUSE  ? mcause_q  : '0;
      mtvec_o = mtvec_q;
      mepc_o  = mepc_q;
   end
endmodule

// File: rtl/ysyx_25040129_wbu.sv
// ysyx_25040129_wbu: write-back/commit stage that retires one instruction and hands the next PC to the IFU
module ysyx_25040129_wbu
   import ysyx_25040129_wbu_pkg::*;
#(
   parameter logic [31:0] MSTATUS_RST = MSTATUS_RST_VAL,
   parameter logic [31:0] ECALL_CAUSE = ECALL_CAUSE_VAL
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        is_req_valid_from_lsu,
   output logic        is_req_ready_to_lsu,
   input  logic [31:0] pc_in_wbu,
   input  logic [31:0] result_in_wbu,
   input  logic [4:0]  rd_in_wbu,
   input  logic [31:0] branch_target_in_wbu,
   input  logic        is_branch_in_wbu,
   input  logic        ecall_in_wbu,
   input  logic        mret_in_wbu,
   input  logic        csr_wen_in_wbu,
   input  logic [11:0] csr_waddr_in_wbu,
   input  logic [31:0] csr_wdata_in_wbu,
   input  logic [11:0] csr_raddr,
   output logic [31:0] csr_rdata,
   output logic        gpr_wen,
   output logic [4:0]  gpr_waddr,
   output logic [31:0] gpr_wdata,
   output logic [31:0] npc,
   output logic        is_req_valid_to_ifu,
   input  logic        is_req_ready_from_ifu
);
   wbu_state_e  state_q;
   logic [31:0] pc_q, result_q, target_q, csr_wdata_q, npc_q;
   logic [4:0]  rd_q;
   logic [11:0] csr_waddr_q;
   logic        branch_q, ecall_q, mret_q, csr_wen_q;
   logic [31:0] mtvec, mepc;

   ysyx_25040129_csr_file #(
      .MSTATUS_RST(MSTATUS_RST),
      .ECALL_CAUSE(ECALL_CAUSE)
   ) u_csr (
      .clk     (clk),
      .rst     (rst),
      .commit_i(state_q == COMMIT),
      .ecall_i (ecall_q),
      .mret_i  (mret_q),
      .wen_i   (csr_wen_q),
      .waddr_i (csr_waddr_q),
      .wdata_i (csr_wdata_q),
      .pc_i    (pc_q),
      .raddr_i (csr_raddr),
      .rdata_o (csr_rdata),
      .mtvec_o (mtvec),
      .mepc_o  (mepc)
   );

   // handshake FSM: latch in IDLE, compute npc in COMMIT, hold it until the IFU takes it
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         npc_q       <= '0;
         pc_q        <= '0;
         result_q    <= '0;
         target_q    <= '0;
         rd_q        <= '0;
         branch_q    <= 1'b0;
         ecall_q     <= 1'b0;
         mret_q      <= 1'b0;
         csr_wen_q   <= 1'b0;
         csr_waddr_q <= '0;
         csr_wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (is_req_valid_from_lsu) begin
               state_q     <= COMMIT;
               pc_q        <= pc_in_wbu;
               result_q    <= result_in_wbu;
               target_q    <= branch_target_in_wbu;
               rd_q        <= rd_in_wbu;
               branch_q    <= is_branch_in_wbu;
               ecall_q     <= ecall_in_wbu;
               mret_q      <= mret_in_wbu;
               csr_wen_q   <= csr_wen_in_wbu;
               csr_waddr_q <= csr_waddr_in_wbu;
               csr_wdata_q <= csr_wdata_in_wbu;
            end
            COMMIT: begin
               state_q <= WAIT_IFU;
               npc_q   <= ecall_q ? mtvec : mret_q ? mepc : branch_q ? target_q : pc_q + 32'd4;
            end
            WAIT_IFU: if (is_req_ready_from_ifu) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // outputs derived from registered state; x0 writes and traps never reach the register file
   always_comb begin
      is_req_ready_to_lsu = state_q == IDLE;
      is_req_valid_to_ifu = state_q == WAIT_IFU;
      gpr_wen             = state_q == COMMIT && rd_q != 5'd0 && !ecall_q && !mret_q && !rst;
      gpr_waddr           = rd_q;
      gpr_wdata           = result_q;
      npc                 = npc_q;
   end
endmodule

// File: tb/tb_ysyx_25040129_wbu.sv
// tb_ysyx_25040129_wbu: randomized and directed checks of the write-back stage against a CSR/PC reference model
module tb_ysyx_25040129_wbu;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_lsu = 1'b0;
   logic        ready_lsu;
   logic [31:0] pc_i = '0, res_i = '0, bt_i = '0, cd_i = '0;
   logic [4:0]  rd_i = '0;
   logic        br_i = 1'b0, ec_i = 1'b0, mr_i = 1'b0, cw_i = 1'b0;
   logic [11:0] ca_i = '0, raddr = '0;
   logic [31:0] rdata;
   logic        gpr_wen;
   logic [4:0]  gpr_waddr;
   logic [31:0] gpr_wdata, npc;
   logic        valid_ifu;
   logic        ready_ifu = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

   ysyx_25040129_wbu dut (
      .clk                  (clk),
      .rst                  (rst),
      .is_req_valid_from_lsu(valid_lsu),
      .is_req_ready_to_lsu  (ready_lsu),
      .pc_in_wbu            (pc_i),
      .result_in_wbu        (res_i),
      .rd_in_wbu            (rd_i),
      .branch_target_in_wbu (bt_i),
      .is_branch_in_wbu     (br_i),
      .ecall_in_wbu         (ec_i),
      .mret_in_wbu          (mr_i),
      .csr_wen_in_wbu       (cw_i),
      .csr_waddr_in_wbu     (ca_i),
      .csr_wdata_in_wbu     (cd_i),
      .csr_raddr            (raddr),
      .csr_rdata            (rdata),
      .gpr_wen              (gpr_wen),
      .gpr_waddr            (gpr_waddr),
      .gpr_wdata            (gpr_wdata),
      .npc                  (npc),
      .is_req_valid_to_ifu  (valid_ifu),
      .is_req_ready_from_ifu(ready_ifu)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return m_mstatus;
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_reset();
      m_mstatus = 32'h0000_1800;
      m_mtvec   = 0;
      m_mepc    = 0;
      m_mcause  = 0;
   endtask

   task automatic csr_chk(input logic [11:0] a);
      raddr = a;
      #1;
      chk($sformatf("csr_rd_%03h", a), rdata, m_read(a));
   endtask

   // one full retire: entered and left at a negedge with the DUT in IDLE
   task automatic txn(input logic [31:0] pc, res, bt, input logic [4:0] rd,
                      input logic br, ec, mr, cw, input logic [11:0] ca,
                      input logic [31:0] cd, input int stall, input logic hold);
      logic [31:0] enpc;
      logic        ewen;
      chk("ready_idle", {31'b0, ready_lsu}, 1);
      chk("valid_ifu_idle", {31'b0, valid_ifu}, 0);
      pc_i = pc; res_i = res; bt_i = bt; rd_i = rd;
      br_i = br; ec_i = ec; mr_i = mr; cw_i = cw; ca_i = ca; cd_i = cd;
      valid_lsu = 1'b1;
      ewen = rd != 0 && !ec && !mr;
      enpc = ec ? m_mtvec : mr ? m_mepc : br ? bt : pc + 32'd4;
      @(posedge clk); @(negedge clk);
      if (hold) begin
         pc_i = $urandom; res_i = $urandom; rd_i = 5'd7; ec_i = 1'b0; mr_i = 1'b0;
         cw_i = 1'b1; ca_i = 12'h305; cd_i = $urandom;
      end else valid_lsu = 1'b0;
      chk("gpr_wen", {31'b0, gpr_wen}, {31'b0, ewen});
      chk("gpr_waddr", {27'b0, gpr_waddr}, {27'b0, rd});
      chk("gpr_wdata", gpr_wdata, res);
      chk("ready_commit", {31'b0, ready_lsu}, 0);
      chk("valid_ifu_commit", {31'b0, valid_ifu}, 0);
      if (ec) begin
         m_mepc   = pc & 32'hFFFF_FFFC;
         m_mcause = 32'd11;
      end else if (!mr && cw) begin
         case (ca)
            12'h300: m_mstatus = cd;
            12'h305: m_mtvec   = cd;
            12'h341: m_mepc    = cd & 32'hFFFF_FFFC;
            12'h342: m_mcause  = cd;
            default: ;
         endcase
      end
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < stall; i++) begin
         chk("valid_ifu_stall", {31'b0, valid_ifu}, 1);
         chk("npc_stall", npc, enpc);
         chk("ready_stall", {31'b0, ready_lsu}, 0);
         chk("gpr_wen_stall", {31'b0, gpr_wen}, 0);
         @(posedge clk); @(negedge clk);
      end
      chk("valid_ifu", {31'b0, valid_ifu}, 1);
      chk("npc", npc, enpc);
      ready_ifu = 1'b1;
      @(posedge clk); @(negedge clk);
      ready_ifu = 1'b0;
      valid_lsu = 1'b0;
      chk("valid_ifu_done", {31'b0, valid_ifu}, 0);
      chk("ready_done", {31'b0, ready_lsu}, 1);
      csr_chk(ca);
   endtask

   initial begin
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ready", {31'b0, ready_lsu}, 1);
      chk("rst_gpr_wen", {31'b0, gpr_wen}, 0);
      chk("rst_valid_ifu", {31'b0, valid_ifu}, 0);
      chk("rst_npc", npc, 0);
      chk("rst_waddr", {27'b0, gpr_waddr}, 0);
      chk("rst_wdata", gpr_wdata, 0);
      csr_chk(12'h300);
      csr_chk(12'h305);
      csr_chk(12'h341);
      csr_chk(12'h342);
      @(negedge clk);

      txn(32'h8000_0000, 32'h1234, 0, 5'd5, 0, 0, 0, 0, 0, 0, 0, 0);
      txn(32'h8000_0004, 32'hDEAD, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      txn(32'h8000_0008, 32'h55, 0, 5'd3, 0, 0, 0, 1, 12'h305, 32'h8000_1000, 0, 0);
      txn(32'h8000_0010, 32'h77, 0, 5'd4, 0, 1, 0, 1, 12'h300, 32'hFFFF_FFFF, 0, 0);
      csr_chk(12'h341);
      csr_chk(12'h342);
      csr_chk(12'h300);
      txn(32'h8000_1000, 32'h99, 0, 5'd6, 0, 0, 1, 1, 12'h342, 32'h1, 0, 0);
      csr_chk(12'h342);
      txn(32'h8000_0004, 32'h8000_0008, 32'h8000_0100, 5'd1, 1, 0, 0, 0, 0, 0, 0, 0);
      txn(32'h8000_0100, 32'hABCD, 0, 5'd9, 0, 0, 0, 0, 0, 0, 5, 1);
      txn(32'hFFFF_FFFC, 32'h1, 0, 5'd2, 0, 0, 0, 1, 12'h7C0, 32'h1234, 0, 0);
      txn(32'h8000_0200, 32'h2, 0, 5'd2, 0, 0, 0, 1, 12'h341, 32'h8000_0207, 0, 0);

      // reset lands while a CSR write sits in COMMIT
      pc_i = 32'h8000_0300; rd_i = 5'd8; res_i = 32'h42; br_i = 0; ec_i = 0; mr_i = 0;
      cw_i = 1'b1; ca_i = 12'h341; cd_i = 32'h8000_0400;
      valid_lsu = 1'b1;
      @(posedge clk); @(negedge clk);
      valid_lsu = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_commit_gpr_wen", {31'b0, gpr_wen}, 0);
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      m_reset();
      #1;
      chk("rst_mid_ready", {31'b0, ready_lsu}, 1);
      chk("rst_mid_valid_ifu", {31'b0, valid_ifu}, 0);
      chk("rst_mid_npc", npc, 0);
      csr_chk(12'h341);
      csr_chk(12'h300);
      csr_chk(12'h7C0);
      @(posedge clk); @(negedge clk);
      chk("rst_mid_idle_valid_ifu", {31'b0, valid_ifu}, 0);

      for (int n = 0; n < 200; n++) begin
         logic [11:0] a;
         case ($urandom_range(0, 4))
            0: a = 12'h300;
            1: a = 12'h305;
            2: a = 12'h341;
            3: a = 12'h342;
            default: a = 12'($urandom);
         endcase
         txn($urandom, $urandom, $urandom, 5'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
         csr_chk(12'($urandom_range(0, 3) == 0 ? 12'h305 : 12'h341));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
